// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns,
// anode one-hot-low codes, idle levels and the frame FSM state type.
package seven_seg_pkg;

   localparam int unsigned STABLE_CYCLES_DEFAULT = 16;

   // Active-low abcdefg patterns, indexed by the hex value they display.
   localparam logic [6:0] SEG_PAT [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   localparam logic [3:0] ANODE_CODE [4] = '{
      4'b1110, 4'b1101, 4'b1011, 4'b0111
   };

   localparam logic [3:0] ANODE_IDLE = 4'b1111;
   localparam logic [6:0] SEG_IDLE   = 7'b1111111;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_DONE    = 1'b1
   } frame_state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational seven-segment to hex decoder; valid is low for any
// pattern outside the sixteen-entry table.
module seg7_to_hex
   import seven_seg_pkg::*;
(
   input  logic [6:0] seg_pat,
   output logic [3:0] hex,
   output logic       valid
);

   always_comb begin
      hex   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (seg_pat == SEG_PAT[i]) begin
            hex   = i[3:0];
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Monitors a multiplexed seven-segment display bus and rebuilds the four
// displayed hex digits, flagging each completed frame and bad patterns.
module seven_seg_scan_decoder
   import seven_seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  anode_in,
   input  logic [6:0]  seg_in,
   input  logic        err_clr,
   output logic [15:0] hex_digits,
   output logic [3:0]  digit_mask,
   output logic        frame_valid,
   output logic [3:0]  pattern_err
);

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
   localparam logic [7:0] CAP_AT  = 8'(STABLE_CYCLES - 1);

   logic [3:0]   anode_s1_q, anode_s2_q, prev_anode_q;
   logic [6:0]   seg_s1_q, seg_s2_q, prev_seg_q;
   logic [7:0]   cnt_q, cnt_d;
   logic [15:0]  hex_q, hex_d;
   logic [3:0]   mask_q, mask_d;
   logic [3:0]   err_q, err_d;
   frame_state_e state_q, state_d;

   logic         active;
   logic [1:0]   digit_idx;
   logic         capture;
   logic [3:0]   cap_bit;
   logic [3:0]   dec_hex;
   logic         dec_valid;

   seg7_to_hex u_dec (
      .seg_pat (seg_s2_q),
      .hex     (dec_hex),
      .valid   (dec_valid)
   );

   always_comb begin
      active    = 1'b0;
      digit_idx = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (anode_s2_q == ANODE_CODE[i]) begin
            active    = 1'b1;
            digit_idx = i[1:0];
         end
      end

      if (!active || ({anode_s2_q, seg_s2_q} != {prev_anode_q, prev_seg_q})) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end

      // Saturation keeps cnt_d from revisiting CAP_AT, so one capture per dwell.
      capture = active && (cnt_d == CAP_AT);

      hex_d   = hex_q;
      cap_bit = '0;
      err_d   = err_clr ? '0 : err_q;
      if (capture) begin
         if (dec_valid) begin
            hex_d[{digit_idx, 2'b00} +: 4] = dec_hex;
            cap_bit[digit_idx]             = 1'b1;
         end else begin
            err_d[digit_idx] = 1'b1;
         end
      end

      state_d = state_q;
      mask_d  = mask_q | cap_bit;
      case (state_q)
         ST_COLLECT: begin
            if (mask_d == 4'b1111) state_d = ST_DONE;
         end
         ST_DONE: begin
            // Mask clears, but a capture landing in this cycle survives.
            state_d = ST_COLLECT;
            mask_d  = cap_bit;
         end
         default: state_d = ST_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         anode_s1_q   <= ANODE_IDLE;
         anode_s2_q   <= ANODE_IDLE;
         prev_anode_q <= ANODE_IDLE;
         seg_s1_q     <= SEG_IDLE;
         seg_s2_q     <= SEG_IDLE;
         prev_seg_q   <= SEG_IDLE;
         cnt_q        <= '0;
         hex_q        <= '0;
         mask_q       <= '0;
         err_q        <= '0;
         state_q      <= ST_COLLECT;
      end else begin
         anode_s1_q   <= anode_in;
         anode_s2_q   <= anode_s1_q;
         prev_anode_q <= anode_s2_q;
         seg_s1_q     <= seg_in;
         seg_s2_q     <= seg_s1_q;
         prev_seg_q   <= seg_s2_q;
         cnt_q        <= cnt_d;
         hex_q        <= hex_d;
         mask_q       <= mask_d;
         err_q        <= err_d;
         state_q      <= state_d;
      end
   end

   assign hex_digits  = hex_q;
   assign digit_mask  = mask_q;
   assign pattern_err = err_q;
   assign frame_valid = (state_q == ST_DONE);

endmodule

// File: doc/seven_seg_scan_decoder.md
SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 16, number of consecutive identical synchronized samples required before a digit is captured (legal range 2..255).
REQ-002 Port: clk  input  1  sole clock, all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: anode_in  input  4  monitored digit-enable lines, active-low; 1110=digit0, 1101=digit1, 1011=digit2, 0111=digit3.
REQ-005 Port: seg_in  input  7  monitored segment lines, active-low, bit order abcdefg (bit 6 = a).
REQ-006 Port: err_clr  input  1  synchronous clear of pattern_err.
REQ-007 Port: hex_digits  output  16  reconstructed digits; digit n is held in bits [4n+3:4n].
REQ-008 Port: digit_mask  output  4  digits captured in the current frame; bit n = digit n.
REQ-009 Port: frame_valid  output  1  one-cycle pulse when all four digits have been captured.
REQ-010 Port: pattern_err  output  4  sticky flags; bit n = digit n showed an undecodable pattern.

Function
REQ-011 anode_in and seg_in shall each pass through a 2-flop synchronizer before any use.
REQ-012 A synchronized sample is "active" only when anode is exactly one of the four one-hot-low codes; 1111, or any code with more than one low bit, is idle.
REQ-013 Stability counter: shall reset to 0 whenever the synchronized {anode,seg} differs from the previous sample, or the sample is idle; otherwise it increments and saturates at STABLE_CYCLES.
REQ-014 Capture: shall occur exactly once per dwell, in the cycle the counter reaches STABLE_CYCLES-1 with an active sample; no re-capture until the counter resets.
REQ-015 Decode table, hex:pattern: 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111, 8:0000000, 9:0000100, A:0001000, b:1100000, C:0110001, d:1000010, E:0110000, F:0111000.
REQ-016 Capture of a table pattern: write the nibble of the selected digit and set its digit_mask bit; other nibbles unchanged.
REQ-017 Capture of a non-table pattern: set pattern_err for that digit; nibble and mask unchanged.
REQ-018 Latency: a new value stable on the inputs shall appear on hex_digits/digit_mask at the (STABLE_CYCLES+2)th rising edge after the inputs settle.
REQ-019 Frame FSM, states COLLECT and DONE: COLLECT->DONE on the edge where digit_mask becomes 1111; DONE asserts frame_valid for one cycle, clears digit_mask to 0000 and returns to COLLECT unconditionally on the next edge.
REQ-020 A digit captured again within a frame: nibble overwritten, mask unchanged, no frame_valid.
REQ-021 hex_digits shall hold its last value across frame boundaries; it changes only on a valid capture.
REQ-022 err_clr clears all pattern_err bits; an err_clr in the same cycle as a new error shall leave that error bit set (set wins).
REQ-023 A capture arriving while the FSM is in DONE shall be applied and retained after the mask clear, not lost.

Reset
REQ-024 While rst_n=0: synchronizers to idle (anode 1111, seg 1111111), counter 0, FSM COLLECT, hex_digits 0000, digit_mask 0000, frame_valid 0, pattern_err 0000.
REQ-025 Reset asserted mid-dwell or mid-frame shall discard the partial frame; after release, capture restarts from counter 0 with no spurious frame_valid.

Structure
REQ-026 Package seven_seg_pkg shall hold the 16 segment pattern constants, the four anode one-hot-low codes, and the STABLE_CYCLES default.
REQ-027 Sub-module seg7_to_hex shall be the combinational decoder: 7-bit pattern in, 4-bit hex plus a valid flag out.
REQ-028 Estimated RTL size: 150-300 lines.

Verification
REQ-029 Scan digits 0..3 with patterns 1,2,3,4, each held 40 cycles (STABLE_CYCLES=16) -> hex_digits=16'h4321, single frame_valid pulse, digit_mask returns to 0000.
REQ-030 Digit2 driven with 0101010 for 40 cycles -> pattern_err=0100, nibble 2 unchanged; then err_clr pulse -> pattern_err=0000.
REQ-031 Digit1 held for 10 cycles, then seg changes -> no capture, digit_mask bit1 stays 0.
REQ-032 Anode 1100 (two digits low) held for 100 cycles -> no capture and no error.
REQ-033 rst_n pulsed low after three of four digits are captured -> all outputs return to reset values; a following full scan of A,b,C,d yields 16'hdCbA and exactly one frame_valid.
REQ-034 Digit0 captured twice in one frame (5, then 7) before the other digits -> nibble0=7, one frame_valid at completion.
